// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and channel index type for the 1-to-4 stream demux
package demux_pkg;

  localparam int NUM_CH  = 4;
  localparam int SEL_W   = 2;
  localparam int STALL_W = 16;

  typedef logic [SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/demux_fifo.sv
// rtl/demux_fifo.sv - single-clock per-channel FIFO with registered count and async reset
module demux_fifo #(
  parameter int n     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [n-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [n-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [n-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses a push even if it is popped in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/four_way_demux.sv
// rtl/four_way_demux.sv - registered 1-to-4 stream demux; DEMUX_STALL_CNT_EN adds a saturating stall counter
module four_way_demux
  import demux_pkg::*;
#(
  parameter int n     = 1,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [n-1:0]        in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_CH*n-1:0] out_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready
`ifdef DEMUX_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0]  stall_cnt
`endif
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  // in_ready depends only on in_sel and registered counts, never on out_ready.
  assign in_ready  = ~full[in_sel];
  assign out_valid = ~empty;
  assign pop       = out_ready & out_valid;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_ch
      assign push[k] = in_valid & in_ready & (in_sel == ch_idx_t'(k));

      demux_fifo #(
        .n     (n),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[k]),
        .din   (in_data),
        .pop   (pop[k]),
        .full  (full[k]),
        .empty (empty[k]),
        .head  (out_data[k*n +: n])
      );
    end
  endgenerate

`ifdef DEMUX_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`endif

endmodule
